data_sram_responder: RTL and testbench

- Responder (slave) end of the pipeline's data-SRAM interface. It models the on-chip data RAM that the EXE stage issues load/store requests to.
- Its rdata/data_ok is the word the MEM stage consumes for ld.b/bu/h/hu/w extraction.
- It accepts one request per cycle via a req/addr_ok handshake and holds outstanding requests in an in-order queue. Each request is answered with data_ok exactly LATENCY cycles after acceptance.
- It applies byte-enabled stores and returns full aligned words. Byte/half selection and sign extension are left to the MEM stage.

---
 rtl/data_sram_responder.sv | 100 ++++++++++
 tb/tb_data_sram_responder.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_sram_responder.sv
// Data-SRAM responder: byte-enabled word RAM behind an in-order response queue.
// Every accepted request is answered with data_ok exactly LATENCY cycles later.
module data_sram_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2,
  parameter int DEPTH      = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [3:0]  wstrb,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata,
  output logic        busy
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [2:0]    CNT_INIT = 3'(LATENCY - 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);

  // Handshake: a request transfers on any edge where req && addr_ok. addr_ok
  // depends only on the registered occupancy, so a pop never frees a slot in
  // the same cycle. Responses are never back-pressured.

  logic [31:0]           ram_q [2**ADDR_WIDTH];
  logic [31:0]           word_q [DEPTH];
  logic [2:0]            cnt_q [DEPTH];
  logic [DEPTH-1:0]      load_q;
  logic [DEPTH-1:0]      valid_q;
  logic [PW-1:0]         head_q, head_d;
  logic [PW-1:0]         tail_q, tail_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  push;
  logic                  pop;
  logic [ADDR_WIDTH-1:0] idx;
  logic                  unused_bits;

  assign idx         = addr[ADDR_WIDTH+1:2];
  assign unused_bits = ^{size, addr[31:ADDR_WIDTH+2], addr[1:0]};

  assign addr_ok = (count_q < DEPTH_C);
  assign push    = req && addr_ok && !reset;
  assign pop     = valid_q[head_q] && (cnt_q[head_q] == 3'd0);
  assign data_ok = pop;
  assign rdata   = (pop && load_q[head_q]) ? word_q[head_q] : 32'd0;
  assign busy    = (count_q != '0);

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push) tail_d = tail_q + PW'(1);
    if (pop)  head_d = head_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) cnt_q[i] <= 3'd0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      for (int i = 0; i < DEPTH; i++) begin
        if (valid_q[i] && (cnt_q[i] != 3'd0)) cnt_q[i] <= cnt_q[i] - 3'd1;
      end
      if (pop) valid_q[head_q] <= 1'b0;
      // Loads capture the word as it stood before this edge's store, if any.
      if (push) begin
        valid_q[tail_q] <= 1'b1;
        cnt_q[tail_q]   <= CNT_INIT;
        load_q[tail_q]  <= !wr;
        word_q[tail_q]  <= wr ? 32'd0 : ram_q[idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push && wr) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) ram_q[idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_sram_responder.sv
// Bench for data_sram_responder: three instances (L2/D4, L8/D4, L1/D2) checked
// against directed tables and a queue-based reference model every cycle.
module tb_data_sram_responder;

  localparam int NI = 3;

  typedef struct {
    logic        req;
    logic        wr;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        e_ok;
    logic        e_dok;
    logic [31:0] e_rd;
    logic        e_busy;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_s [NI];
  logic        wr_s [NI];
  logic [1:0]  size_s [NI];
  logic [3:0]  wstrb_s [NI];
  logic [31:0] addr_s [NI];
  logic [31:0] wdata_s [NI];
  logic        addr_ok_s [NI];
  logic        data_ok_s [NI];
  logic [31:0] rdata_s [NI];
  logic        busy_s [NI];

  logic        d_reset;
  logic        d_req [NI];
  logic        d_wr [NI];
  logic [1:0]  d_size [NI];
  logic [3:0]  d_wstrb [NI];
  logic [31:0] d_addr [NI];
  logic [31:0] d_wdata [NI];

  // Scoreboard entry: {due cycle[30:0], data known, data[31:0]}
  logic [63:0] exp_q [NI][$];
  logic [31:0] mem_m [NI][1024];
  bit          known_m [NI][1024];
  int          cyc = 0;
  bit          model_on = 0;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  data_sram_responder #(.ADDR_WIDTH(10), .LATENCY(2), .DEPTH(4)) u0 (
    .clk(clk), .reset(reset), .req(req_s[0]), .wr(wr_s[0]), .size(size_s[0]),
    .wstrb(wstrb_s[0]), .addr(addr_s[0]), .wdata(wdata_s[0]),
    .addr_ok(addr_ok_s[0]), .data_ok(data_ok_s[0]), .rdata(rdata_s[0]), .busy(busy_s[0]));

  data_sram_responder #(.ADDR_WIDTH(10), .LATENCY(8), .DEPTH(4)) u1 (
    .clk(clk), .reset(reset), .req(req_s[1]), .wr(wr_s[1]), .size(size_s[1]),
    .wstrb(wstrb_s[1]), .addr(addr_s[1]), .wdata(wdata_s[1]),
    .addr_ok(addr_ok_s[1]), .data_ok(data_ok_s[1]), .rdata(rdata_s[1]), .busy(busy_s[1]));

  data_sram_responder #(.ADDR_WIDTH(10), .LATENCY(1), .DEPTH(2)) u2 (
    .clk(clk), .reset(reset), .req(req_s[2]), .wr(wr_s[2]), .size(size_s[2]),
    .wstrb(wstrb_s[2]), .addr(addr_s[2]), .wdata(wdata_s[2]),
    .addr_ok(addr_ok_s[2]), .data_ok(data_ok_s[2]), .rdata(rdata_s[2]), .busy(busy_s[2]));

  function automatic int lat_of(int k);
    return (k == 0) ? 2 : (k == 1) ? 8 : 1;
  endfunction

  function automatic int dep_of(int k);
    return (k == 2) ? 2 : 4;
  endfunction

  function automatic logic [31:0] pw(int i);
    return 32'h5A00_0000 ^ (32'(i) * 32'h0001_0203);
  endfunction

  function automatic vec_t mk(logic rq, logic w, logic [3:0] s, logic [31:0] a, logic [31:0] d,
                              logic ok, logic dok, logic [31:0] rd, logic bz);
    vec_t v;
    v.req = rq; v.wr = w; v.wstrb = s; v.addr = a; v.wdata = d;
    v.e_ok = ok; v.e_dok = dok; v.e_rd = rd; v.e_busy = bz;
    return v;
  endfunction

  task automatic chk(string name, int k, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s inst%0d cyc%0d: got %h expected %h", name, k, cyc, act, exp);
    end
  endtask

  task automatic idle_all();
    for (int k = 0; k < NI; k++) begin
      d_req[k] = 1'b0; d_wr[k] = 1'b0; d_size[k] = 2'd2; d_wstrb[k] = 4'h0;
      d_addr[k] = 32'd0; d_wdata[k] = 32'd0;
    end
  endtask

  task automatic model_check(int k);
    int          n;
    logic [63:0] h;
    bit          e_dok;
    n = exp_q[k].size();
    h = '0;
    e_dok = 0;
    if (n > 0) begin
      h = exp_q[k][0];
      e_dok = (int'(h[63:33]) == cyc);
    end
    chk("m_addr_ok", k, 32'(addr_ok_s[k]), 32'(n < dep_of(k)));
    chk("m_data_ok", k, 32'(data_ok_s[k]), 32'(e_dok));
    if (!e_dok || h[32]) chk("m_rdata", k, rdata_s[k], e_dok ? h[31:0] : 32'd0);
    chk("m_busy", k, 32'(busy_s[k]), 32'(n != 0));
  endtask

  task automatic model_update(int k);
    int         n;
    bit         e_ok;
    int         due;
    logic [9:0] idx;
    n = exp_q[k].size();
    e_ok = (n < dep_of(k));
    if (n > 0 && int'(exp_q[k][0][63:33]) == cyc) void'(exp_q[k].pop_front());
    if (d_reset) begin
      exp_q[k].delete();
    end else if (d_req[k] && e_ok) begin
      idx = d_addr[k][11:2];
      due = cyc + lat_of(k);
      if (d_wr[k]) begin
        exp_q[k].push_back({31'(due), 1'b1, 32'd0});
        for (int b = 0; b < 4; b++) begin
          if (d_wstrb[k][b]) mem_m[k][idx][8*b +: 8] = d_wdata[k][8*b +: 8];
        end
        if (d_wstrb[k] == 4'hF) known_m[k][idx] = 1'b1;
      end else begin
        exp_q[k].push_back({31'(due), known_m[k][idx], mem_m[k][idx]});
      end
    end
  endtask

  // One cycle: drive at the falling edge, sample 1ns later, advance the model.
  task automatic tick();
    @(negedge clk);
    reset = d_reset;
    for (int k = 0; k < NI; k++) begin
      req_s[k] = d_req[k]; wr_s[k] = d_wr[k]; size_s[k] = d_size[k];
      wstrb_s[k] = d_wstrb[k]; addr_s[k] = d_addr[k]; wdata_s[k] = d_wdata[k];
    end
    #1;
    if (model_on) for (int k = 0; k < NI; k++) model_check(k);
    for (int k = 0; k < NI; k++) model_update(k);
    cyc++;
  endtask

  task automatic drain();
    int t;
    idle_all();
    t = 0;
    while ((busy_s[0] || busy_s[1] || busy_s[2]) && t < 40) begin
      tick();
      t++;
    end
    chk("drain_busy", 0, 32'({busy_s[0], busy_s[1], busy_s[2]}), 32'd0);
  endtask

  initial begin
    static int cycle_budget = 0;
    vec_t tv [14];
    int   p [NI];

    for (int k = 0; k < NI; k++)
      for (int i = 0; i < 1024; i++) begin
        mem_m[k][i] = 32'd0;
        known_m[k][i] = 1'b0;
      end

    // Reset and idle outputs
    d_reset = 1'b1;
    idle_all();
    tick();
    tick();
    d_reset = 1'b0;
    model_on = 1;
    tick();
    for (int k = 0; k < NI; k++) begin
      chk("rst_addr_ok", k, 32'(addr_ok_s[k]), 32'd1);
      chk("rst_data_ok", k, 32'(data_ok_s[k]), 32'd0);
      chk("rst_rdata", k, rdata_s[k], 32'd0);
      chk("rst_busy", k, 32'(busy_s[k]), 32'd0);
    end

    // Preload words 0..15 in every instance, retrying while the queue is full
    for (int k = 0; k < NI; k++) p[k] = 0;
    while ((p[0] < 16 || p[1] < 16 || p[2] < 16) && cycle_budget < 300) begin
      for (int k = 0; k < NI; k++) begin
        d_req[k] = (p[k] < 16); d_wr[k] = 1'b1; d_wstrb[k] = 4'hF;
        d_addr[k] = 32'(p[k]) * 4; d_wdata[k] = pw(p[k]);
      end
      tick();
      cycle_budget++;
      for (int k = 0; k < NI; k++) if (d_req[k] && addr_ok_s[k]) p[k]++;
    end
    chk("preload_done", 0, 32'(p[0] + p[1] + p[2]), 32'd48);
    drain();

    // Directed table on the LATENCY=2 instance
    tv[0]  = mk(1, 1, 4'hF, 32'h100, 32'h1234_5678, 1, 0, 32'h0, 0);
    tv[1]  = mk(1, 0, 4'h0, 32'h100, 32'h0,         1, 0, 32'h0, 1);
    tv[2]  = mk(0, 0, 4'h0, 32'h0,   32'h0,         1, 1, 32'h0, 1);
    tv[3]  = mk(0, 0, 4'h0, 32'h0,   32'h0,         1, 1, 32'h1234_5678, 1);
    tv[4]  = mk(1, 1, 4'hF, 32'h40,  32'hAABB_CCDD, 1, 0, 32'h0, 0);
    tv[5]  = mk(1, 1, 4'h4, 32'h40,  32'h00EE_0000, 1, 0, 32'h0, 1);
    tv[6]  = mk(1, 0, 4'h0, 32'h42,  32'h0,         1, 1, 32'h0, 1);
    tv[7]  = mk(1, 1, 4'hF, 32'h200, 32'h1111_1111, 1, 1, 32'h0, 1);
    tv[8]  = mk(1, 0, 4'h0, 32'h200, 32'h0,         1, 1, 32'hAAEE_CCDD, 1);
    tv[9]  = mk(1, 1, 4'hF, 32'h200, 32'h2222_2222, 1, 1, 32'h0, 1);
    tv[10] = mk(1, 0, 4'h0, 32'h200, 32'h0,         1, 1, 32'h1111_1111, 1);
    tv[11] = mk(0, 0, 4'h0, 32'h0,   32'h0,         1, 1, 32'h0, 1);
    tv[12] = mk(0, 0, 4'h0, 32'h0,   32'h0,         1, 1, 32'h2222_2222, 1);
    tv[13] = mk(0, 0, 4'h0, 32'h0,   32'h0,         1, 0, 32'h0, 0);
    idle_all();
    for (int r = 0; r < 14; r++) begin
      d_req[0] = tv[r].req; d_wr[0] = tv[r].wr; d_wstrb[0] = tv[r].wstrb;
      d_addr[0] = tv[r].addr; d_wdata[0] = tv[r].wdata;
      tick();
      chk("tv_addr_ok", 0, 32'(addr_ok_s[0]), 32'(tv[r].e_ok));
      chk("tv_data_ok", 0, 32'(data_ok_s[0]), 32'(tv[r].e_dok));
      chk("tv_rdata", 0, rdata_s[0], tv[r].e_rd);
      chk("tv_busy", 0, 32'(busy_s[0]), 32'(tv[r].e_busy));
    end
    drain();

    // Full queue at LATENCY=8, DEPTH=4 with req held high through the pop cycle
    idle_all();
    for (int c = 0; c <= 12; c++) begin
      d_req[1] = (c <= 8);
      d_addr[1] = 32'((c < 4) ? c : 4) * 4;
      tick();
      chk("full_addr_ok", 1, 32'(addr_ok_s[1]), 32'((c < 4) || (c >= 9)));
      chk("full_data_ok", 1, 32'(data_ok_s[1]), 32'((c >= 8) && (c <= 11)));
      chk("full_rdata", 1, rdata_s[1], ((c >= 8) && (c <= 11)) ? pw(c - 8) : 32'd0);
      chk("full_busy", 1, 32'(busy_s[1]), 32'((c >= 1) && (c <= 11)));
    end
    drain();

    // Streaming at LATENCY=1, DEPTH=2; first load uses 0x1000 which aliases word 0
    idle_all();
    for (int c = 0; c <= 17; c++) begin
      d_req[2] = (c < 16);
      d_addr[2] = (c == 0) ? 32'h1000 : 32'(c) * 4;
      tick();
      chk("strm_addr_ok", 2, 32'(addr_ok_s[2]), 32'd1);
      chk("strm_data_ok", 2, 32'(data_ok_s[2]), 32'((c >= 1) && (c <= 16)));
      chk("strm_rdata", 2, rdata_s[2], ((c >= 1) && (c <= 16)) ? pw(c - 1) : 32'd0);
    end
    drain();

    // Reset with three loads outstanding: none of them may be answered
    idle_all();
    for (int c = 0; c < 3; c++) begin
      d_req[1] = 1'b1;
      d_addr[1] = 32'(c + 5) * 4;
      tick();
    end
    idle_all();
    d_reset = 1'b1;
    tick();
    d_reset = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("mrst_data_ok", 1, 32'(data_ok_s[1]), 32'd0);
      chk("mrst_addr_ok", 1, 32'(addr_ok_s[1]), 32'd1);
      chk("mrst_busy", 1, 32'(busy_s[1]), 32'd0);
    end

    // Random traffic on all instances, compared against the model each cycle
    for (int c = 0; c < 600; c++) begin
      d_reset = ($urandom_range(0, 299) == 0);
      for (int k = 0; k < NI; k++) begin
        d_req[k] = ($urandom_range(0, 3) != 0);
        d_wr[k] = $urandom_range(0, 1) == 1;
        d_size[k] = 2'($urandom_range(0, 2));
        d_wstrb[k] = 4'($urandom_range(0, 15));
        d_addr[k] = ($urandom & ~32'hFFC) | (32'($urandom_range(0, 15)) << 2);
        d_wdata[k] = $urandom;
      end
      tick();
    end
    d_reset = 1'b0;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
